// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-organised data RAM for the load/store path.
// Byte/half/word access with little-endian lane steering, sign/zero
// extension of loads, and a REQ/READY handshake with WAIT_CYC wait states.
// Out-of-range, reserved-size and optionally misaligned accesses complete
// with ERR=1, no RAM write and RDATA=0.
// Optional macro DM_MISALIGN_TRAP_EN: trap misaligned half/word accesses.
// Without it, misaligned addresses are force-aligned.
// DEPTH must be at least 5 to hold the power-up image.
module data_mem_ctrl #(
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              WE,
  input  logic [1:0]        SIZE,
  input  logic              UNS,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       WDATA,
  output logic [31:0]       RDATA,
  output logic              READY,
  output logic              BUSY,
  output logic              ERR
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              ready_q;
  logic              busy_q;
  logic              err_q;

  // Contents survive reset; only the power-up image is preloaded.
  logic [31:0] mem_q [DEPTH] = '{
    0: 32'd17,
    1: 32'd31,
    2: 32'hFFFF_FFFB,
    3: 32'hFFFF_FFFE,
    4: 32'd250,
    default: '0
  };

  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [1:0]        acc_size;
  logic              acc_uns;
  logic [31:0]       acc_wdata;

  logic              complete;
  logic [ADDR_W-3:0] acc_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              oor;
  logic              misalign;
  logic [1:0]        lane;
  logic              err_d;
  logic [31:0]       rd_word;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       load_v;
  logic [31:0]       rdata_d;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic              commit_we;

  // With no wait states the access completes on its accepting edge, so the
  // live inputs are decoded there; otherwise the captured copies are used.
  always_comb begin
    if ((WAIT_CYC == 0) && (state_q == IDLE)) begin
      acc_addr  = ADDR;
      acc_we    = WE;
      acc_size  = SIZE;
      acc_uns   = UNS;
      acc_wdata = WDATA;
    end else begin
      acc_addr  = addr_q;
      acc_we    = we_q;
      acc_size  = size_q;
      acc_uns   = uns_q;
      acc_wdata = wdata_q;
    end
  end

  // Completion strobe: high in the cycle whose closing edge enters DONE
  always_comb begin
    complete = 1'b0;
    unique case (state_q)
      IDLE:    complete = REQ && (WAIT_CYC == 0);
      WAIT:    complete = (cnt_q == '0);
      default: complete = 1'b0;
    endcase
  end

  // Address decode, error classification and lane selection
  always_comb begin
    acc_idx = acc_addr[ADDR_W-1:2];
    mem_idx = acc_idx[IDX_W-1:0];
    oor     = 32'(acc_idx) >= DEPTH;
    lane    = acc_addr[1:0];
`ifdef DM_MISALIGN_TRAP_EN
    misalign = ((acc_size == 2'b01) && acc_addr[0]) ||
               ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
    if (acc_size == 2'b01) lane[0] = 1'b0;
    if (acc_size == 2'b10) lane    = 2'b00;
`endif
    err_d = oor || (acc_size == 2'b11) || misalign;
  end

  // Load path: extract the addressed byte/half and extend it
  always_comb begin
    rd_word = oor ? '0 : mem_q[mem_idx];
    byte_v  = rd_word[{lane, 3'b000} +: 8];
    half_v  = rd_word[{lane[1], 4'b0000} +: 16];
    unique case (acc_size)
      2'b00:   load_v = {{24{byte_v[7] & ~acc_uns}}, byte_v};
      2'b01:   load_v = {{16{half_v[15] & ~acc_uns}}, half_v};
      default: load_v = rd_word;
    endcase
    rdata_d = (err_d || acc_we) ? '0 : load_v;
  end

  // Store path: replicate right-aligned data across lanes and build byte enables
  always_comb begin
    unique case (acc_size)
      2'b00: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = acc_wdata;
      end
    endcase
    commit_we = complete && !RST && acc_we && !err_d;
  end

  // RAM write port: commits a valid store on the edge entering DONE
  always_ff @(posedge CLK) begin
    if (commit_we) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (st_be[k]) mem_q[mem_idx][8*k +: 8] <= st_data[8*k +: 8];
      end
    end
  end

  // Handshake FSM with registered RDATA/READY/BUSY/ERR
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (complete) begin
        ready_q <= 1'b1;
        err_q   <= err_d;
        rdata_q <= rdata_d;
      end
      unique case (state_q)
        IDLE: begin
          if (REQ) begin
            addr_q  <= ADDR;
            we_q    <= WE;
            size_q  <= SIZE;
            uns_q   <= UNS;
            wdata_q <= WDATA;
            busy_q  <= 1'b1;
            if (WAIT_CYC == 0) begin
              state_q <= DONE;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_CYC - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= DONE;
          else             cnt_q   <= cnt_q - 4'd1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RDATA = rdata_q;
  assign READY = ready_q;
  assign BUSY  = busy_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: directed vector table, reset-abort sequence
// and randomized traffic against a byte-addressed reference model.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned AW    = 12;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST1, RST3, REQ1, REQ3;
  logic          WE, UNS;
  logic [1:0]    SIZE;
  logic [AW-1:0] ADDR;
  logic [31:0]   WDATA;
  logic [31:0]   RDATA1, RDATA3;
  logic          READY1, READY3, BUSY1, BUSY3, ERR1, ERR3;

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .WAIT_CYC(1)) u_w1 (
    .CLK(CLK), .RST(RST1), .REQ(REQ1), .WE(WE), .SIZE(SIZE), .UNS(UNS),
    .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA1), .READY(READY1),
    .BUSY(BUSY1), .ERR(ERR1)
  );

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .WAIT_CYC(3)) u_w3 (
    .CLK(CLK), .RST(RST3), .REQ(REQ3), .WE(WE), .SIZE(SIZE), .UNS(UNS),
    .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA3), .READY(READY3),
    .BUSY(BUSY3), .ERR(ERR3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic o_ready(input int d);
    return (d == 3) ? READY3 : READY1;
  endfunction
  function automatic logic o_busy(input int d);
    return (d == 3) ? BUSY3 : BUSY1;
  endfunction
  function automatic logic o_err(input int d);
    return (d == 3) ? ERR3 : ERR1;
  endfunction
  function automatic logic [31:0] o_rdata(input int d);
    return (d == 3) ? RDATA3 : RDATA1;
  endfunction

  // Reference model: plain byte array, little-endian multi-byte accesses
  logic [7:0] ref_b [4*DEPTH];

  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [AW-1:0] a, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd);
    int unsigned ea, nb;
    logic [31:0] v;
    ea  = a;
    nb  = 1 << sz;
    err = 1'b0;
    rd  = '0;
    if ((ea / 4) >= DEPTH || sz == 2'b11) err = 1'b1;
    if (!err && (ea % nb) != 0) begin
`ifdef DM_MISALIGN_TRAP_EN
      err = 1'b1;
`else
      ea = ea - (ea % nb);
`endif
    end
    if (!err) begin
      if (we) begin
        for (int unsigned i = 0; i < nb; i++) ref_b[ea+i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int unsigned i = 0; i < nb; i++) v = v | (32'(ref_b[ea+i]) << (8*i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
        rd = v;
      end
    end
  endtask

  // One full transaction: lat = edges from accept to READY (-1 on timeout),
  // busy_n = samples with BUSY high, extra = READY pulses after completion.
  task automatic run_txn(input int d, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [AW-1:0] a,
                         input logic [31:0] wd, input bit hold,
                         output logic err, output logic [31:0] rd,
                         output int lat, output int busy_n, output int extra);
    int n;
    bit hit;
    @(negedge CLK);
    WE = we; SIZE = sz; UNS = uns; ADDR = a; WDATA = wd;
    if (d == 3) REQ3 = 1'b1; else REQ1 = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) begin REQ1 = 1'b0; REQ3 = 1'b0; end
    WE = 1'($urandom); SIZE = 2'($urandom); UNS = 1'($urandom);
    ADDR = AW'($urandom); WDATA = $urandom;
    n = 0; hit = 0; busy_n = 0; err = 1'b0; rd = '0;
    while (n < 40 && !hit) begin
      if (o_busy(d)) busy_n++;
      if (o_ready(d)) begin
        hit = 1;
        err = o_err(d);
        rd  = o_rdata(d);
      end else begin
        @(posedge CLK);
        #1;
        n++;
      end
    end
    lat = hit ? n : -1;
    REQ1 = 1'b0; REQ3 = 1'b0;
    @(posedge CLK);
    #1;
    if (o_busy(d)) busy_n++;
    extra = o_ready(d) ? 1 : 0;
    if (hold) begin
      repeat (4) begin
        @(posedge CLK);
        #1;
        if (o_ready(d)) extra++;
      end
    end
  endtask

  typedef struct {
    string         name;
    logic          we;
    logic [1:0]    sz;
    logic          uns;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic          chk_rd;
    logic [31:0]   exp_rd;
    logic          exp_err;
    bit            hold;
  } vec_t;

  vec_t vt[$];

  task automatic add(input string n, input logic we, input logic [1:0] sz,
                     input logic uns, input logic [AW-1:0] a, input logic [31:0] wd,
                     input logic c, input logic [31:0] er, input logic ee, input bit h);
    vec_t v;
    v.name = n; v.we = we; v.sz = sz; v.uns = uns; v.addr = a; v.wd = wd;
    v.chk_rd = c; v.exp_rd = er; v.exp_err = ee; v.hold = h;
    vt.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic          e, me;
    logic [31:0]   r, mr;
    int            lat, bn, ex;
    int            img [5] = '{17, 31, -5, -2, 250};
    logic [31:0]   t32;

    for (int unsigned i = 0; i < 4*DEPTH; i++) ref_b[i] = 8'h00;
    for (int unsigned w = 0; w < 5; w++) begin
      t32 = img[w];
      for (int unsigned b = 0; b < 4; b++) ref_b[4*w+b] = t32[8*b +: 8];
    end

    RST1 = 1'b1; RST3 = 1'b1; REQ1 = 1'b0; REQ3 = 1'b0;
    WE = 1'b0; SIZE = 2'b00; UNS = 1'b0; ADDR = '0; WDATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rdata", RDATA1, 32'h0);
    chk("rst_ready", {31'b0, READY1}, 32'h0);
    chk("rst_busy",  {31'b0, BUSY1},  32'h0);
    chk("rst_err",   {31'b0, ERR1},   32'h0);
    chk("rst3_busy", {31'b0, BUSY3},  32'h0);
    @(negedge CLK);
    RST1 = 1'b0; RST3 = 1'b0;

    //   name        we   sz     uns   addr     wdata         chk   exp_rd        err   hold
    add("ld_w0",     0, 2'b10, 0, 12'h000, 32'h0,        1, 32'h0000_0011, 0, 0);
    add("st_b2",     1, 2'b00, 0, 12'h002, 32'h0000_0080, 0, 32'h0,        0, 0);
    add("ld_sb2",    0, 2'b00, 0, 12'h002, 32'h0,        1, 32'hFFFF_FF80, 0, 0);
    add("ld_ub2",    0, 2'b00, 1, 12'h002, 32'h0,        1, 32'h0000_0080, 0, 0);
    add("ld_w0b",    0, 2'b10, 0, 12'h000, 32'h0,        1, 32'h0080_0011, 0, 0);
    add("ld_sh8",    0, 2'b01, 0, 12'h008, 32'h0,        1, 32'hFFFF_FFFB, 0, 0);
    add("ld_uh10",   0, 2'b01, 1, 12'h00A, 32'h0,        1, 32'h0000_FFFF, 0, 0);
    add("rsvd8",     0, 2'b11, 0, 12'h008, 32'h0,        1, 32'h0,        1, 0);
`ifdef DM_MISALIGN_TRAP_EN
    add("ld_w5",     0, 2'b10, 0, 12'h005, 32'h0,        1, 32'h0,        1, 0);
    add("ld_sh9",    0, 2'b01, 0, 12'h009, 32'h0,        1, 32'h0,        1, 0);
`else
    add("ld_w5",     0, 2'b10, 0, 12'h005, 32'h0,        1, 32'h0000_001F, 0, 0);
    add("ld_sh9",    0, 2'b01, 0, 12'h009, 32'h0,        1, 32'hFFFF_FFFB, 0, 0);
`endif
    add("st_oor",    1, 2'b10, 0, 12'h800, 32'hDEAD_BEEF, 1, 32'h0,        1, 1);
    add("ld_w0c",    0, 2'b10, 0, 12'h000, 32'h0,        1, 32'h0080_0011, 0, 0);
    add("ld_wlast",  0, 2'b10, 0, 12'h7FC, 32'h0,        1, 32'h0,        0, 0);
    add("st_h14",    1, 2'b01, 0, 12'h00E, 32'h1234_BEEF, 0, 32'h0,        0, 0);
    add("ld_w12",    0, 2'b10, 0, 12'h00C, 32'h0,        1, 32'hBEEF_FFFE, 0, 0);
    add("ld_ub16",   0, 2'b00, 1, 12'h010, 32'h0,        1, 32'h0000_00FA, 0, 0);
    add("ld_sb16",   0, 2'b00, 0, 12'h010, 32'h0,        1, 32'hFFFF_FFFA, 0, 0);
    add("ld_sb19",   0, 2'b00, 0, 12'h013, 32'h0,        1, 32'h0,        0, 0);
    add("st_wlast",  1, 2'b10, 0, 12'h7FC, 32'hCAFE_F00D, 0, 32'h0,        0, 0);
    add("ld_uhlast", 0, 2'b01, 1, 12'h7FE, 32'h0,        1, 32'h0000_CAFE, 0, 0);

    foreach (vt[i]) begin
      model(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd, me, mr);
      run_txn(1, vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd, vt[i].hold,
              e, r, lat, bn, ex);
      chk({vt[i].name, "_lat"}, 32'(lat), 32'd1);
      chk({vt[i].name, "_busy"}, 32'(bn), 32'd2);
      chk({vt[i].name, "_extra"}, 32'(ex), 32'd0);
      chk({vt[i].name, "_err"}, {31'b0, e}, {31'b0, vt[i].exp_err});
      if (vt[i].chk_rd) chk({vt[i].name, "_rd"}, r, vt[i].exp_rd);
    end

    // Reset during WAIT on the 3-wait-state instance discards the store
    run_txn(3, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0, e, r, lat, bn, ex);
    chk("w3_ld16_lat", 32'(lat), 32'd3);
    chk("w3_ld16_busy", 32'(bn), 32'd4);
    chk("w3_ld16_rd", r, 32'h0000_00FA);
    @(negedge CLK);
    WE = 1'b1; SIZE = 2'b10; UNS = 1'b0; ADDR = 12'h00C; WDATA = 32'h1234_5678;
    REQ3 = 1'b1;
    @(posedge CLK);
    #1;
    REQ3 = 1'b0;
    @(posedge CLK);
    #1;
    chk("w3_busy_prerst", {31'b0, BUSY3}, 32'h1);
    RST3 = 1'b1;
    #1;
    chk("w3_rst_rdata", RDATA3, 32'h0);
    chk("w3_rst_ready", {31'b0, READY3}, 32'h0);
    chk("w3_rst_busy",  {31'b0, BUSY3},  32'h0);
    chk("w3_rst_err",   {31'b0, ERR3},   32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST3 = 1'b0;
    ex = 0;
    repeat (6) begin
      @(posedge CLK);
      #1;
      if (READY3) ex++;
    end
    chk("w3_no_ready_after_rst", 32'(ex), 32'd0);
    run_txn(3, 1'b0, 2'b10, 1'b0, 12'h00C, 32'h0, 1'b0, e, r, lat, bn, ex);
    chk("w3_ld12_lat", 32'(lat), 32'd3);
    chk("w3_ld12_err", {31'b0, e}, 32'h0);
    chk("w3_ld12_rd", r, 32'hFFFF_FFFE);

    // Randomized traffic on the 1-wait-state instance
    for (int t = 0; t < 200; t++) begin
      int unsigned   wi;
      logic [AW-1:0] a;
      logic [1:0]    sz;
      logic          we, uns;
      logic [31:0]   wd;
      wi  = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 2, DEPTH + 5)
                                         : $urandom_range(0, 7);
      a   = AW'(wi * 4 + $urandom_range(0, 3));
      sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      we  = ($urandom_range(0, 2) == 0);
      uns = 1'($urandom);
      wd  = $urandom;
      model(we, sz, uns, a, wd, me, mr);
      run_txn(1, we, sz, uns, a, wd, 1'b0, e, r, lat, bn, ex);
      chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'd1);
      chk($sformatf("rnd%0d_err", t), {31'b0, e}, {31'b0, me});
      if (!we || me) chk($sformatf("rnd%0d_rd a=%h sz=%0d", t, a, sz), r, mr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
